instr_encoder: RTL and testbench

Sequential instruction encoder and program loader: the write-side counterpart of the control decoder. It accepts symbolic instructions (mnemonic plus operand) over a valid/ready stream and packs each into the 9-bit machine-code format the decoder consumes. It buffers the words in a small FIFO and writes them to consecutive instruction-memory addresses from a programmable base. It sits between the test/boot host and instruction memory.

---
 rtl/instr_encoder.sv | 147 ++++++++++++++
 tb/tb_instr_encoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Symbolic instruction encoder and program loader: packs mnemonic/operand pairs into
// 9-bit machine words, buffers them in a small FIFO and writes them to consecutive addresses.
module instr_encoder #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW:0]   i_count,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [3:0]    i_mnem,
    input  logic [5:0]    i_operand,
    output logic          o_im_we,
    output logic [AW-1:0] o_im_addr,
    output logic [8:0]    o_im_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FILL_FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic [8:0]      r_fifo [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW:0]     r_fill;
    logic [AW:0]     r_count;
    logic [AW:0]     r_pushed;
    logic [AW-1:0]   r_wr_ptr;
    logic            r_err;
    logic            r_im_we;
    logic [AW-1:0]   r_im_addr;
    logic [8:0]      r_im_wdata;

    logic            w_legal;
    logic            w_in_ready;
    logic            w_xfer;
    logic            w_push;
    logic            w_pop;
    logic            w_start;
    logic [8:0]      w_word;

    assign w_legal    = (i_mnem <= 4'd13);
    assign w_in_ready = (r_state == S_LOAD) && (r_fill != FILL_FULL) && (r_pushed < r_count);
    assign w_xfer     = i_in_valid && w_in_ready;
    assign w_push     = w_xfer && w_legal;
    assign w_pop      = ((r_state == S_LOAD) || (r_state == S_DRAIN)) && (r_fill != '0);
    assign w_start    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Funct-class groups carry a 2-bit funct in [1:0]; the rest take the full operand.
    always_comb begin
        w_word = '0;
        case (i_mnem)
            4'd0, 4'd1, 4'd2, 4'd3:  w_word = {3'b000, i_operand[3:0], i_mnem[1:0]};
            4'd4:                    w_word = {3'b001, i_operand};
            4'd5, 4'd6, 4'd7, 4'd8:  w_word = {3'b010, i_operand[3:0], i_mnem[1:0] - 2'd1};
            4'd9, 4'd10, 4'd11, 4'd12, 4'd13:
                                     w_word = {i_mnem[2:0] - 3'd6, i_operand};
            default:                 w_word = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_tail] <= w_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill     <= '0;
            r_count    <= '0;
            r_pushed   <= '0;
            r_wr_ptr   <= '0;
            r_err      <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
        end else begin
            r_im_we <= w_pop;
            if (w_pop) begin
                r_im_addr  <= r_wr_ptr;
                r_im_wdata <= r_fifo[r_head];
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_head     <= r_head + PW'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (PW+1)'(1);
                2'b01:   r_fill <= r_fill - (PW+1)'(1);
                default: r_fill <= r_fill;
            endcase
            if (w_xfer && !w_legal) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_wr_ptr <= i_base_addr;
                        r_count  <= i_count;
                        r_pushed <= '0;
                        r_err    <= 1'b0;
                        r_head   <= '0;
                        r_tail   <= '0;
                        r_fill   <= '0;
                        r_state  <= (i_count == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_push) begin
                        r_pushed <= r_pushed + (AW+1)'(1);
                        if (r_pushed + (AW+1)'(1) == r_count) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // An empty FIFO here means the last word's write strobe is already out.
                    if (r_fill == '0) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_im_we    = r_im_we;
    assign o_im_addr  = r_im_addr;
    assign o_im_wdata = r_im_wdata;
    assign o_busy     = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign o_done     = (r_state == S_DONE);
    assign o_err      = r_err;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a table-driven model schedules each expected write
// two cycles after its accept, and a per-cycle compare process checks the write port.
module tb_instr_encoder;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          in_valid = 1'b0;
    logic [3:0]    mnem = '0;
    logic [5:0]    operand = '0;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [8:0]    im_wdata;
    logic          busy;
    logic          done;
    logic          err;

    instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
        .i_count(count), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_mnem(mnem), .i_operand(operand), .o_im_we(im_we), .o_im_addr(im_addr),
        .o_im_wdata(im_wdata), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Mnemonic table: opcode and funct (-1 = operand-class) for LOAD..RXOR.
    int opc_t [14] = '{0, 0, 0, 0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    int fn_t  [14] = '{0, 1, 2, 3, -1, 0, 1, 2, 3, -1, -1, -1, -1, -1};

    logic [16:0] exp_w [int];
    logic [8:0]  wlog [int];
    int          wcyc [$];
    int          n_writes = 0;
    int          last_we_cyc = -10;
    int          stalls = 0;
    int          first_acc = -1;
    int          m_k = 0;
    int          m_count = 0;
    logic [7:0]  m_base = '0;
    bit          m_err = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] model_enc(int m, logic [5:0] op);
        logic [2:0] o;
        o = 3'(opc_t[m]);
        if (fn_t[m] >= 0) return {o, op[3:0], 2'(fn_t[m])};
        return {o, op};
    endfunction

    function automatic logic [8:0] getw(int k);
        if (wlog.exists(k)) return wlog[k];
        return 9'h1FF;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_w.exists(cyc)) begin
                chk("im_we", 32'(im_we), 32'd1);
                chk("im_addr", 32'(im_addr), 32'(exp_w[cyc][16:9]));
                chk("im_wdata", 32'(im_wdata), 32'(exp_w[cyc][8:0]));
                exp_w.delete(cyc);
            end else begin
                chk("im_we_quiet", 32'(im_we), 32'd0);
            end
            chk("busy_done_excl", 32'(busy & done), 32'd0);
            if (im_we) begin
                wlog[int'(im_addr)] = im_wdata;
                n_writes++;
                last_we_cyc = cyc;
                wcyc.push_back(cyc);
                $display("write  cyc=%0d addr=0x%02h data=0x%03h", cyc, im_addr, im_wdata);
            end
        end
    end

    task automatic chk_zero(string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_im_we"}, 32'(im_we), 32'd0);
        chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
        chk({tag, "_im_wdata"}, 32'(im_wdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic new_test();
        n_writes = 0;
        wlog.delete();
        wcyc.delete();
        stalls = 0;
        first_acc = -1;
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_start(logic [7:0] b, logic [8:0] c, bit honoured);
        start = 1'b1;
        base_addr = b;
        count = c;
        if (honoured) begin
            m_base = b;
            m_count = int'(c);
            m_k = 0;
            m_err = 1'b0;
        end
        $display("start  cyc=%0d base=0x%02h count=%0d honoured=%0d", cyc, b, c, honoured);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic accept(int m, logic [5:0] op);
        if (first_acc < 0) first_acc = cyc;
        if (m <= 13 && m_k < m_count) begin
            exp_w[cyc + 2] = {m_base + 8'(m_k), model_enc(m, op)};
            m_k++;
        end else if (m > 13) begin
            m_err = 1'b1;
        end
        $display("accept cyc=%0d mnem=%0d op=0x%02h", cyc, m, op);
    endtask

    task automatic send(int m, logic [5:0] op);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        mnem = 4'(m);
        operand = op;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accept(m, op);
                got = 1'b1;
                @(posedge clk); #1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen;
        int dc;
        seen = 1'b0;
        dc = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dc = cyc;
                break;
            end
        end
        chk("done_timeout", 32'(seen), 32'd1);
        if (seen && n_writes > 0) chk("done_after_last_we", 32'(dc), 32'(last_we_cyc + 1));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then reset in the middle of a load.
        #1 chk_zero("rst0");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        new_test();
        do_start(8'h40, 9'd6, 1'b1);
        send(0, 6'h01);
        send(0, 6'h02);
        send(0, 6'h03);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_w.delete();
        #1 chk_zero("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_we", 32'(im_we), 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        new_test();
        do_start(8'h20, 9'd2, 1'b1);
        send(0, 6'h05);
        send(1, 6'h3F);
        wait_done();
        chk("post_rst_n", 32'(n_writes), 32'd2);
        chk("post_rst_w0", 32'(getw(8'h20)), 32'h014);
        chk("post_rst_w1", 32'(getw(8'h21)), 32'h03D);

        // Hand-computed encodings.
        new_test();
        do_start(8'h15, 9'd3, 1'b1);
        send(6, 6'b001011);
        send(9, 6'h2A);
        send(13, 6'h00);
        wait_done();
        chk("pin_addi", 32'(getw(8'h15)), 32'h0AD);
        chk("pin_jal", 32'(getw(8'h16)), 32'h0EA);
        chk("pin_rxor", 32'(getw(8'h17)), 32'h1C0);
        chk("pin_n", 32'(n_writes), 32'd3);

        // Encoding sweep over every legal mnemonic.
        new_test();
        do_start(8'h10, 9'd14, 1'b1);
        for (int m = 0; m < 14; m++) send(m, 6'h2B);
        wait_done();
        chk("sweep_n", 32'(n_writes), 32'd14);
        chk("sweep_err", 32'(err), 32'd0);
        chk("sweep_addi", 32'(getw(8'h16)), 32'h0AD);
        chk("sweep_jal", 32'(getw(8'h19)), 32'h0EB);

        // Illegal mnemonic is dropped and flags err.
        new_test();
        do_start(8'h30, 9'd2, 1'b1);
        chk("ill_err_pre", 32'(err), 32'd0);
        send(5, 6'h03);
        send(15, 6'h3F);
        chk("ill_err_rise", 32'(err), 32'd1);
        send(7, 6'h01);
        wait_done();
        chk("ill_n", 32'(n_writes), 32'd2);
        chk("ill_w0", 32'(getw(8'h30)), 32'h08C);
        chk("ill_w1", 32'(getw(8'h31)), 32'h086);
        chk("ill_err", 32'(err), 32'(m_err));
        chk("ill_done", 32'(done), 32'd1);

        // Sustained throughput with in_valid held high.
        new_test();
        do_start(8'h80, 9'd8, 1'b1);
        chk("tp_err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < 8; i++) send(10 + (i % 4), 6'(i * 7));
        @(negedge clk);
        chk("tp_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("tp_stalls", 32'(stalls), 32'd0);
        wait_done();
        chk("tp_n", 32'(wcyc.size()), 32'd8);
        if (wcyc.size() == 8) begin
            chk("tp_first_we", 32'(wcyc[0]), 32'(first_acc + 2));
            chk("tp_last_we", 32'(wcyc[7]), 32'(first_acc + 9));
        end

        // Address wrap.
        new_test();
        do_start(8'hFE, 9'd3, 1'b1);
        send(4, 6'h11);
        send(11, 6'h22);
        send(3, 6'h33);
        wait_done();
        chk("wrap_fe", 32'(getw(8'hFE)), 32'h051);
        chk("wrap_ff", 32'(getw(8'hFF)), 32'h162);
        chk("wrap_00", 32'(getw(8'h00)), 32'h00F);

        // Zero count goes straight to done.
        new_test();
        do_start(8'h55, 9'd0, 1'b1);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("zero_no_we", 32'(n_writes), 32'd0);

        // Start during a load is ignored.
        new_test();
        do_start(8'h60, 9'd4, 1'b1);
        send(12, 6'h01);
        send(2, 6'h02);
        in_valid = 1'b0;
        do_start(8'hA0, 9'd2, 1'b0);
        chk("ign_busy", 32'(busy), 32'd1);
        send(8, 6'h03);
        send(0, 6'h04);
        wait_done();
        chk("ign_n", 32'(n_writes), 32'd4);
        chk("ign_w3", 32'(getw(8'h63)), 32'h010);
        chk("ign_no_a0", 32'(getw(8'hA0)), 32'h1FF);

        chk("exp_drained", 32'(exp_w.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
